// File: rtl/bus_if.sv
// bus_if: memory-access front end for one pipeline stage.
// Accesses that hit the scratchpad (addr[29:27] == SPM_INDEX) complete in the
// same cycle with no wait. Other accesses go to the external bus through a
// request/grant/strobe/ready handshake.
// Ports:
//   clk, reset         - clock, asynchronous active-high reset
//   stall, flush       - pipeline control for the owning stage
//   addr, as_, rw,     - stage access request (as_ active-low, rw 1 = read)
//   wr_data
//   busy, rd_data      - hold request and load data back to the stage
//   spm_*              - scratchpad port (strobe active-low)
//   bus_*              - external bus master port (req_, as_, rdy_, grnt_ active-low)
module bus_if #(
   parameter int unsigned SPM_INDEX = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   output logic        busy,
   input  logic [29:0] addr,
   input  logic        as_,
   input  logic        rw,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   input  logic [31:0] spm_rd_data,
   output logic [11:0] spm_addr,
   output logic        spm_as_,
   output logic        spm_rw,
   output logic [31:0] spm_wr_data,
   input  logic [31:0] bus_rd_data,
   input  logic        bus_rdy_,
   input  logic        bus_grnt_,
   output logic        bus_req_,
   output logic [29:0] bus_addr,
   output logic        bus_as_,
   output logic        bus_rw,
   output logic [31:0] bus_wr_data
);

   localparam int unsigned ADDR_W = 30;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned SEL_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_ACCESS = 2'd2,
      ST_STALL  = 2'd3
   } state_t;

   // Registered external bus master signals.
   typedef struct packed {
      logic              req_n;
      logic              as_n;
      logic [ADDR_W-1:0] addr;
      logic              rw;
      logic [DATA_W-1:0] wr_data;
   } bus_regs_t;

   localparam bus_regs_t BUS_IDLE = '{
      req_n:   1'b1,
      as_n:    1'b1,
      addr:    '0,
      rw:      1'b1,
      wr_data: '0
   };

   state_t            state_q, state_d;
   bus_regs_t         bus_q, bus_d;
   logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
   logic              spm_hit;

   assign spm_hit = (addr[29:27] == SEL_W'(SPM_INDEX));

   // Scratchpad address/direction/data follow the stage directly.
   assign spm_addr    = addr[11:0];
   assign spm_rw      = rw;
   assign spm_wr_data = wr_data;

   assign bus_req_    = bus_q.req_n;
   assign bus_as_     = bus_q.as_n;
   assign bus_addr    = bus_q.addr;
   assign bus_rw      = bus_q.rw;
   assign bus_wr_data = bus_q.wr_data;

   // State and bus register update; reset drops any transaction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         bus_q    <= BUS_IDLE;
         rd_buf_q <= '0;
      end else begin
         state_q  <= state_d;
         bus_q    <= bus_d;
         rd_buf_q <= rd_buf_d;
      end
   end

   // Next state, bus register updates and stage-facing outputs.
   always_comb begin
      state_d  = state_q;
      bus_d    = bus_q;
      rd_buf_d = rd_buf_q;
      busy     = 1'b0;
      rd_data  = '0;
      spm_as_  = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (!flush && !as_) begin
               if (spm_hit) begin
                  spm_as_ = 1'b0;
                  rd_data = spm_rd_data;
               end else begin
                  busy          = 1'b1;
                  state_d       = ST_REQ;
                  bus_d.req_n   = 1'b0;
                  bus_d.addr    = addr;
                  bus_d.rw      = rw;
                  bus_d.wr_data = wr_data;
               end
            end
         end

         // Ready is not looked at until the grant has been taken.
         ST_REQ: begin
            busy = 1'b1;
            if (!bus_grnt_) begin
               state_d    = ST_ACCESS;
               bus_d.as_n = 1'b0;
            end
         end

         // Strobe is dropped after the first access cycle; flush is ignored.
         ST_ACCESS: begin
            bus_d.as_n = 1'b1;
            if (!bus_rdy_) begin
               if (bus_q.rw) begin
                  rd_data  = bus_rd_data;
                  rd_buf_d = bus_rd_data;
               end
               bus_d   = BUS_IDLE;
               state_d = stall ? ST_STALL : ST_IDLE;
            end else begin
               busy = 1'b1;
            end
         end

         // Stage is stalled: keep presenting the last load result.
         ST_STALL: begin
            rd_data = rd_buf_q;
            if (!stall) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bus_if.sv
// Testbench for bus_if: directed scenarios with literal checks, plus a
// transaction-level model compared against every output on each falling edge.
module tb_bus_if;

   localparam logic [2:0] SPM_IDX = 3'd3;

   logic        clk         = 1'b0;
   logic        reset       = 1'b0;
   logic        stall       = 1'b0;
   logic        flush       = 1'b0;
   logic [29:0] addr        = '0;
   logic        as_         = 1'b1;
   logic        rw          = 1'b1;
   logic [31:0] wr_data     = '0;
   logic [31:0] spm_rd_data = '0;
   logic [31:0] bus_rd_data = '0;
   logic        bus_rdy_    = 1'b1;
   logic        bus_grnt_   = 1'b1;

   logic        busy;
   logic [31:0] rd_data;
   logic [11:0] spm_addr;
   logic        spm_as_;
   logic        spm_rw;
   logic [31:0] spm_wr_data;
   logic        bus_req_;
   logic [29:0] bus_addr;
   logic        bus_as_;
   logic        bus_rw;
   logic [31:0] bus_wr_data;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   bus_if #(.SPM_INDEX(32'd3)) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .flush       (flush),
      .busy        (busy),
      .addr        (addr),
      .as_         (as_),
      .rw          (rw),
      .wr_data     (wr_data),
      .rd_data     (rd_data),
      .spm_rd_data (spm_rd_data),
      .spm_addr    (spm_addr),
      .spm_as_     (spm_as_),
      .spm_rw      (spm_rw),
      .spm_wr_data (spm_wr_data),
      .bus_rd_data (bus_rd_data),
      .bus_rdy_    (bus_rdy_),
      .bus_grnt_   (bus_grnt_),
      .bus_req_    (bus_req_),
      .bus_addr    (bus_addr),
      .bus_as_     (bus_as_),
      .bus_rw      (bus_rw),
      .bus_wr_data (bus_wr_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic bit hit_f(input logic [29:0] a);
      return (a[29:27] == SPM_IDX);
   endfunction

   // Transaction-level model: one outstanding bus transfer, a granted flag,
   // cycles since grant, and whether the stage is holding the last load.
   bit          m_txn     = 1'b0;
   bit          m_granted = 1'b0;
   bit          m_holding = 1'b0;
   int          m_acc_cnt = 0;
   logic [29:0] m_addr    = '0;
   logic        m_rw      = 1'b1;
   logic [31:0] m_wdata   = '0;
   logic [31:0] m_last_rd = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_txn     <= 1'b0;
         m_granted <= 1'b0;
         m_holding <= 1'b0;
         m_acc_cnt <= 0;
         m_addr    <= '0;
         m_rw      <= 1'b1;
         m_wdata   <= '0;
         m_last_rd <= '0;
      end else if (m_holding) begin
         if (!stall) m_holding <= 1'b0;
      end else if (m_txn && !m_granted) begin
         if (!bus_grnt_) begin
            m_granted <= 1'b1;
            m_acc_cnt <= 0;
         end
      end else if (m_txn) begin
         if (!bus_rdy_) begin
            if (m_rw) m_last_rd <= bus_rd_data;
            m_txn     <= 1'b0;
            m_granted <= 1'b0;
            m_holding <= stall;
         end else begin
            m_acc_cnt <= m_acc_cnt + 1;
         end
      end else if (!flush && !as_ && !hit_f(addr)) begin
         m_txn   <= 1'b1;
         m_addr  <= addr;
         m_rw    <= rw;
         m_wdata <= wr_data;
      end
   end

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      bit          idle_strobe;
      bit          done;
      logic        e_busy;
      logic [31:0] e_rd;
      if (check_en) begin
         idle_strobe = !m_txn && !m_holding && !flush && !as_;
         done        = m_txn && m_granted && !bus_rdy_;
         if (m_holding)     e_busy = 1'b0;
         else if (m_txn)    e_busy = !done;
         else               e_busy = idle_strobe && !hit_f(addr);
         if (m_holding)                        e_rd = m_last_rd;
         else if (done)                        e_rd = m_rw ? bus_rd_data : 32'd0;
         else if (idle_strobe && hit_f(addr))  e_rd = spm_rd_data;
         else                                  e_rd = 32'd0;
         chk("m_busy",        32'(busy),        32'(e_busy));
         chk("m_rd_data",     rd_data,          e_rd);
         chk("m_spm_as_",     32'(spm_as_),     32'(!(idle_strobe && hit_f(addr))));
         chk("m_spm_addr",    32'(spm_addr),    32'(addr[11:0]));
         chk("m_spm_rw",      32'(spm_rw),      32'(rw));
         chk("m_spm_wr_data", spm_wr_data,      wr_data);
         chk("m_bus_req_",    32'(bus_req_),    32'(!m_txn));
         chk("m_bus_as_",     32'(bus_as_),     32'(!(m_txn && m_granted && m_acc_cnt == 0)));
         chk("m_bus_addr",    32'(bus_addr),    m_txn ? 32'(m_addr) : 32'd0);
         chk("m_bus_rw",      32'(bus_rw),      m_txn ? 32'(m_rw) : 32'd1);
         chk("m_bus_wr_data", bus_wr_data,      m_txn ? m_wdata : 32'd0);
      end
   end

   // Bus read at 0x10: grant on third request cycle, ready on fourth access cycle.
   task automatic bus_read(input bit hold);
      addr = 30'h00000010; rw = 1'b1; as_ = 1'b0;
      bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = 32'hFFFF_FFFF;
      #2;
      chk("rd_idle_busy", 32'(busy), 32'd1);
      cyc(1); as_ = 1'b1; #2;
      chk("rd_req_req_",  32'(bus_req_), 32'd0);
      chk("rd_req_addr",  32'(bus_addr), 32'h10);
      chk("rd_req_busy",  32'(busy),     32'd1);
      cyc(1);
      cyc(1); bus_grnt_ = 1'b0;
      cyc(1); bus_grnt_ = 1'b1; #2;
      chk("rd_acc1_as_",  32'(bus_as_),  32'd0);
      chk("rd_acc1_req_", 32'(bus_req_), 32'd0);
      cyc(1); #2;
      chk("rd_acc2_as_",  32'(bus_as_),  32'd1);
      chk("rd_acc2_req_", 32'(bus_req_), 32'd0);
      cyc(1);
      cyc(1); bus_rdy_ = 1'b0; bus_rd_data = 32'h12345678; stall = hold; #2;
      chk("rd_rdy_data",  rd_data,       32'h12345678);
      chk("rd_rdy_busy",  32'(busy),     32'd0);
      cyc(1); bus_rdy_ = 1'b1; bus_rd_data = 32'h0BAD0BAD; #2;
      chk("rd_done_req_", 32'(bus_req_), 32'd1);
      chk("rd_done_addr", 32'(bus_addr), 32'd0);
   endtask

   initial begin
      #2 reset = 1'b1;
      cyc(2);
      chk("rst_req_",  32'(bus_req_),  32'd1);
      chk("rst_as_",   32'(bus_as_),   32'd1);
      chk("rst_addr",  32'(bus_addr),  32'd0);
      chk("rst_rw",    32'(bus_rw),    32'd1);
      chk("rst_wdata", bus_wr_data,    32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      reset = 1'b0;
      check_en = 1'b1;
      cyc(1);

      // Zero-wait scratchpad read.
      addr = 30'h18000004; rw = 1'b1; as_ = 1'b0; spm_rd_data = 32'hDEADBEEF; #2;
      chk("spm_as_",   32'(spm_as_),  32'd0);
      chk("spm_busy",  32'(busy),     32'd0);
      chk("spm_rd",    rd_data,       32'hDEADBEEF);
      chk("spm_addr",  32'(spm_addr), 32'h004);
      cyc(1); #2;
      chk("spm_no_req", 32'(bus_req_), 32'd1);
      as_ = 1'b1;
      cyc(1);

      // External bus read without and with a stall after ready.
      bus_read(1'b0);
      cyc(1);
      bus_read(1'b1);
      for (int i = 0; i < 4; i++) begin
         cyc(1); #2;
         chk("stall_hold_rd",   rd_data,   32'h12345678);
         chk("stall_hold_busy", 32'(busy), 32'd0);
      end
      cyc(1); stall = 1'b0; #2;
      chk("stall_last_rd", rd_data, 32'h12345678);
      cyc(1); #2;
      chk("stall_idle_rd", rd_data, 32'd0);

      // Write with grant and ready together in the request cycle.
      addr = 30'h08000000; rw = 1'b0; wr_data = 32'hA5A5A5A5; as_ = 1'b0; #2;
      chk("wr_idle_busy", 32'(busy), 32'd1);
      cyc(1); as_ = 1'b1; bus_grnt_ = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = 32'h77777777; #2;
      chk("wr_req_rw",    32'(bus_rw),  32'd0);
      chk("wr_req_wdata", bus_wr_data,  32'hA5A5A5A5);
      chk("wr_req_busy",  32'(busy),    32'd1);
      chk("wr_req_as_",   32'(bus_as_), 32'd1);
      cyc(1); bus_grnt_ = 1'b1; stall = 1'b1; #2;
      chk("wr_acc_busy",  32'(busy),    32'd0);
      chk("wr_acc_rd",    rd_data,      32'd0);
      chk("wr_acc_as_",   32'(bus_as_), 32'd0);
      cyc(1); bus_rdy_ = 1'b1; #2;
      chk("wr_done_rw",    32'(bus_rw),   32'd1);
      chk("wr_done_wdata", bus_wr_data,   32'd0);
      chk("wr_stall_rdbuf", rd_data,      32'h12345678);
      stall = 1'b0;
      cyc(2);

      // Flush in idle blocks both bus and scratchpad.
      flush = 1'b1; as_ = 1'b0; rw = 1'b1; addr = 30'h00000020; #2;
      chk("fl_idle_busy", 32'(busy), 32'd0);
      chk("fl_idle_rd",   rd_data,   32'd0);
      cyc(1); #2;
      chk("fl_idle_req_", 32'(bus_req_), 32'd1);
      addr = 30'h18000000; #2;
      chk("fl_spm_as_",   32'(spm_as_), 32'd1);

      // Flush during request/access does not cancel the transfer.
      flush = 1'b0; addr = 30'h00000020;
      cyc(1); as_ = 1'b1; flush = 1'b1; bus_grnt_ = 1'b0;
      cyc(1); bus_grnt_ = 1'b1;
      cyc(1); bus_rdy_ = 1'b0; bus_rd_data = 32'hCAFEF00D; #2;
      chk("fl_acc_rd",   rd_data,   32'hCAFEF00D);
      chk("fl_acc_busy", 32'(busy), 32'd0);
      cyc(1); bus_rdy_ = 1'b1; flush = 1'b0; #2;
      chk("fl_done_req_", 32'(bus_req_), 32'd1);
      cyc(1);

      // Asynchronous reset in the first access cycle.
      addr = 30'h00000040; rw = 1'b1; as_ = 1'b0;
      cyc(1); as_ = 1'b1; bus_grnt_ = 1'b0;
      cyc(1); bus_grnt_ = 1'b1; #2;
      chk("rs_pre_as_", 32'(bus_as_), 32'd0);
      reset = 1'b1; #1;
      chk("rs_req_",  32'(bus_req_), 32'd1);
      chk("rs_as_",   32'(bus_as_),  32'd1);
      chk("rs_addr",  32'(bus_addr), 32'd0);
      cyc(1); reset = 1'b0;
      cyc(2); #2;
      chk("rs_no_retry", 32'(bus_req_), 32'd1);
      chk("rs_idle_busy", 32'(busy),    32'd0);
      cyc(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
